// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and helpers for the cache-line / memory-burst adaptor.
package cacheline_adaptor_pkg;

    // Transaction phases: wait for a request, move beats, report completion.
    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_e;

    // Direction of the captured transaction.
    typedef enum logic {
        RD,
        WR
    } rw_e;

    // Bit offset of beat slot `idx` inside a line made of `beat_w`-bit beats.
    function automatic int slice_lsb(input int idx, input int beat_w);
        return idx * beat_w;
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// LLC-side line port plus memory-side beat port of the adaptor.
// The adaptor takes the slave view; the LLC/memory environment takes the master view.
interface cacheline_burst_adaptor_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) ();

    // LLC side
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;

    // Memory side
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/burst_beat_counter.sv
// Beat slot index and beat count for one burst. The index starts at the loaded
// slot and wraps modulo BEATS; the count always starts at zero so `last_o`
// marks the final beat whatever the starting slot.
module burst_beat_counter #(
    parameter int BEATS  = 4,
    parameter int BIDX_W = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [BIDX_W-1:0] start_i,
    input  logic              adv_i,
    output logic [BIDX_W-1:0] idx_o,
    output logic              last_o
);

    logic [BIDX_W-1:0] idx_q, idx_d;
    logic [BIDX_W-1:0] cnt_q, cnt_d;

    // Next index/count: a load restarts the burst, each accepted beat advances both.
    always_comb begin
        // NOTE: defaults first so every path assigns idx_d/cnt_d and no latch is inferred.
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (load_i) begin
            idx_d = start_i;
            cnt_d = '0;
        end else if (adv_i) begin
            idx_d = idx_q + BIDX_W'(1);
            cnt_d = cnt_q + BIDX_W'(1);
        end
    end

    // Index/count registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register updates together at the edge.
        if (reset) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign idx_o  = idx_q;
    // BEATS is a power of two, so a count of BEATS-1 is all ones.
    assign last_o = &cnt_q;

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Bridges a whole-line LLC port to a beat-wide burst memory port. Writes split
// the captured line into BEATS beats from slot 0; reads assemble BEATS beats
// into line_o, optionally starting at the addressed beat and wrapping.
module cacheline_burst_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_W          = 256,
    parameter int BURST_W         = 64,
    parameter int ADDR_W          = 32,
    parameter int CRIT_WORD_FIRST = 0
) (
    input logic                     clk,
    input logic                     reset,
    cacheline_burst_adaptor_if.slave bus
);

    localparam int BEATS  = LINE_W / BURST_W;
    localparam int BIDX_W = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int BOFF_W = $clog2(BURST_W / 8);

    state_e              state_q;
    rw_e                 rw_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BIDX_W-1:0]   start_d;
    logic [LINE_W-1:0]   wbuf_q;
    logic [LINE_W-1:0]   line_q;
    logic                read_q, write_q, resp_q;
    logic [BIDX_W-1:0]   idx;
    logic                last;
    logic                start;
    logic                accept;
    logic                unused_addr_bits;

    assign start  = (state_q == IDLE) && (bus.read_i || bus.write_i);
    assign accept = (state_q == BURST) && bus.resp_i;

    // Byte-offset bits below a beat never select anything.
    assign unused_addr_bits = ^bus.address_i[BOFF_W-1:0];

    // Memory address and first beat slot; only critical-word-first reads keep the beat offset.
    always_comb begin
        addr_d  = {bus.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        start_d = '0;
        if (CRIT_WORD_FIRST != 0 && bus.read_i) begin
            addr_d  = {bus.address_i[ADDR_W-1:BOFF_W], {BOFF_W{1'b0}}};
            start_d = bus.address_i[OFF_W-1 -: BIDX_W];
        end
    end

    burst_beat_counter #(
        .BEATS  (BEATS),
        .BIDX_W (BIDX_W)
    ) u_beat_counter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (start),
        .start_i (start_d),
        .adv_i   (accept),
        .idx_o   (idx),
        .last_o  (last)
    );

    // Write line buffer, captured on the request edge.
    always_ff @(posedge clk) begin
        // NOTE: wbuf_q is pure data, always loaded before it is driven out, so it carries no reset.
        if (start && !bus.read_i) begin
            wbuf_q <= bus.line_i;
        end
    end

    // Transaction FSM with registered strobes, address, completion pulse and read line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rw_q    <= RD;
            addr_q  <= '0;
            line_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= BURST;
                        rw_q    <= bus.read_i ? RD : WR;
                        addr_q  <= addr_d;
                        read_q  <= bus.read_i;
                        write_q <= !bus.read_i;
                    end
                end
                BURST: begin
                    if (bus.resp_i) begin
                        if (rw_q == RD) begin
                            line_q[slice_lsb(int'(idx), BURST_W) +: BURST_W] <= bus.burst_i;
                        end
                        if (last) begin
                            state_q <= DONE;
                            read_q  <= 1'b0;
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.line_o    = line_q;
    assign bus.resp_o    = resp_q;
    assign bus.address_o = addr_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.burst_o   = write_q ? wbuf_q[slice_lsb(int'(idx), BURST_W) +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor. Five instances cover the width
// ratios and critical-word-first; `sel` picks which one sees requests and
// resp_i, and whose outputs are observed. A bench-side memory line supplies
// read beats and collects write beats.
module tb_cacheline_burst_adaptor;

    localparam logic [255:0] A_LINE = 256'hA3A3A3A3A3A3A3A3_A2A2A2A2A2A2A2A2_A1A1A1A1A1A1A1A1_A0A0A0A0A0A0A0A0;
    localparam logic [255:0] B_LINE = 256'hB3B3B3B3B3B3B3B3_B2B2B2B2B2B2B2B2_B1B1B1B1B1B1B1B1_B0B0B0B0B0B0B0B0;
    localparam logic [255:0] C_LINE = 256'hC3C3C3C3C3C3C3C3_C2C2C2C2C2C2C2C2_C1C1C1C1C1C1C1C1_C0C0C0C0C0C0C0C0;
    localparam logic [255:0] D_LINE = 256'hD3D3D3D3D3D3D3D3_D2D2D2D2D2D2D2D2_D1D1D1D1D1D1D1D1_D0D0D0D0D0D0D0D0;
    localparam logic [255:0] E_LINE = 256'hE3E3E3E3E3E3E3E3_E2E2E2E2E2E2E2E2_E1E1E1E1E1E1E1E1_E0E0E0E0E0E0E0E0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Shared stimulus, sized for the widest instance
    logic [511:0] line_s;
    logic [31:0]  addr_s;
    logic         rd_s, wr_s, resp_s;
    logic [127:0] burst_s;
    logic [2:0]   sel;

    // Per-instance outputs and the selected view of them
    logic [511:0] line_a  [5];
    logic [127:0] burst_a [5];
    logic [31:0]  addr_a  [5];
    logic         rdo_a   [5];
    logic         wro_a   [5];
    logic         resp_a  [5];
    logic [511:0] line_m;
    logic [127:0] burst_m;
    logic [31:0]  addr_m;
    logic         rdo_m, wro_m, resp_m;

    assign line_m  = line_a[sel];
    assign burst_m = burst_a[sel];
    assign addr_m  = addr_a[sel];
    assign rdo_m   = rdo_a[sel];
    assign wro_m   = wro_a[sel];
    assign resp_m  = resp_a[sel];

    for (genvar g = 0; g < 5; g++) begin : g_cfg
        localparam int LW  = (g == 2) ? 512 : (g == 3) ? 128 : 256;
        localparam int BW  = (g == 2) ? 128 : (g <= 1) ? 64 : 32;
        localparam int CWF = (g == 1) ? 1 : 0;

        cacheline_burst_adaptor_if #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(32)) bus ();

        assign bus.line_i    = line_s[LW-1:0];
        assign bus.address_i = addr_s;
        assign bus.read_i    = rd_s && (sel == g);
        assign bus.write_i   = wr_s && (sel == g);
        assign bus.burst_i   = burst_s[BW-1:0];
        assign bus.resp_i    = resp_s && (sel == g);

        assign line_a[g]  = 512'(bus.line_o);
        assign burst_a[g] = 128'(bus.burst_o);
        assign addr_a[g]  = bus.address_o;
        assign rdo_a[g]   = bus.read_o;
        assign wro_a[g]   = bus.write_o;
        assign resp_a[g]  = bus.resp_o;

        cacheline_burst_adaptor #(
            .LINE_W          (LW),
            .BURST_W         (BW),
            .ADDR_W          (32),
            .CRIT_WORD_FIRST (CWF)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    int           n_cmp;
    int           n_bad;
    logic [511:0] mem;
    logic [511:0] model_line [5];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on instance `sel`. line_s holds the write line; `mem`
    // supplies read beats and receives write beats. pat bit n = resp_i in burst cycle n.
    task automatic xfer(input string tag, input bit is_wr, input bit both,
                        input logic [31:0] a, input logic [31:0] exp_a, input int first,
                        input int nb, input int bw, input int lw, input logic [31:0] pat);
        logic [511:0] wl, lmask, bmask;
        int idx, acc, cyc;
        lmask = {512{1'b1}} >> (512 - lw);
        bmask = {512{1'b1}} >> (512 - bw);
        wl    = line_s;
        rd_s  = !is_wr;
        wr_s  = is_wr || both;
        addr_s = a;
        tick();
        // Request drops and inputs change after capture; neither may matter now.
        rd_s   = 1'b0;
        wr_s   = 1'b0;
        addr_s = ~a;
        line_s = ~wl;
        check({tag, " address_o"}, 512'(addr_m), 512'(exp_a));
        idx = first;
        acc = 0;
        cyc = 0;
        while (acc < nb && cyc < 64) begin
            resp_s  = pat[cyc % 32];
            burst_s = 128'((mem >> (idx * bw)) & bmask);
            check({tag, " read_o held"}, 512'(rdo_m), 512'(!is_wr));
            check({tag, " write_o held"}, 512'(wro_m), 512'(is_wr));
            check({tag, " resp_o quiet"}, 512'(resp_m), 512'(0));
            if (is_wr) begin
                check({tag, " burst_o"}, 512'(burst_m), (wl >> (idx * bw)) & bmask);
                if (resp_s) begin
                    mem = (mem & ~(bmask << (idx * bw))) | ((512'(burst_m) & bmask) << (idx * bw));
                end
            end else begin
                check({tag, " burst_o idle"}, 512'(burst_m), 512'(0));
            end
            tick();
            if (resp_s) begin
                idx = (idx + 1) % nb;
                acc++;
            end
            cyc++;
        end
        resp_s = 1'b0;
        if (!is_wr) begin
            model_line[sel] = mem & lmask;
        end
        check({tag, " resp_o pulse"}, 512'(resp_m), 512'(1));
        check({tag, " read_o low"}, 512'(rdo_m), 512'(0));
        check({tag, " write_o low"}, 512'(wro_m), 512'(0));
        check({tag, " burst_o low"}, 512'(burst_m), 512'(0));
        check({tag, " line_o"}, line_m, model_line[sel]);
        tick();
        check({tag, " resp_o one cycle"}, 512'(resp_m), 512'(0));
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        sel     = 3'd0;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
        resp_s  = 1'b0;
        line_s  = '0;
        addr_s  = '0;
        burst_s = '0;
        mem     = '0;
        for (int i = 0; i < 5; i++) model_line[i] = '0;

        // Reset state
        reset = 1'b1;
        #12;
        check("reset read_o", 512'(rdo_m), 512'(0));
        check("reset write_o", 512'(wro_m), 512'(0));
        check("reset resp_o", 512'(resp_m), 512'(0));
        check("reset address_o", 512'(addr_m), 512'(0));
        check("reset line_o", line_m, 512'(0));
        check("reset burst_o", 512'(burst_m), 512'(0));
        reset = 1'b0;
        tick();

        // resp_i while idle is ignored
        resp_s  = 1'b1;
        burst_s = '1;
        tick();
        tick();
        resp_s = 1'b0;
        check("idle resp read_o", 512'(rdo_m), 512'(0));
        check("idle resp resp_o", 512'(resp_m), 512'(0));
        check("idle resp line_o", line_m, 512'(0));

        // 1: plain read, no stalls
        sel = 3'd0;
        mem = 512'(A_LINE);
        xfer("t1", 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5660, 0, 4, 64, 256, '1);
        check("t1 line literal", line_m, 512'(A_LINE));

        // 2: write with stalls 1,0,1,0,1,1
        line_s = 512'(D_LINE);
        mem    = '0;
        xfer("t2", 1'b1, 1'b0, 32'h0000_ABCD, 32'h0000_ABC0, 0, 4, 64, 256, 32'b110101);
        check("t2 memory image", mem, 512'(D_LINE));
        check("t2 line_o untouched", line_m, 512'(A_LINE));

        // 3: critical-word-first reads wrap from the addressed beat; writes still start at 0
        sel = 3'd1;
        mem = 512'(C_LINE);
        xfer("t3a", 1'b0, 1'b0, 32'h0000_0150, 32'h0000_0150, 2, 4, 64, 256, '1);
        check("t3a line literal", line_m, 512'(C_LINE));
        mem = 512'(A_LINE);
        xfer("t3b", 1'b0, 1'b0, 32'h0000_01FF, 32'h0000_01F8, 3, 4, 64, 256, 32'h0000_00AB);
        line_s = 512'(E_LINE);
        mem    = '0;
        xfer("t3c", 1'b1, 1'b0, 32'h0000_0150, 32'h0000_0140, 0, 4, 64, 256, '1);
        check("t3c memory image", mem, 512'(E_LINE));

        // 4: read and write together -> read wins
        sel = 3'd0;
        mem = 512'(B_LINE);
        xfer("t4", 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 0, 4, 64, 256, '1);

        // 5: reset after two beats aborts asynchronously
        mem    = 512'(C_LINE);
        rd_s   = 1'b1;
        addr_s = 32'h0000_001F;
        tick();
        rd_s   = 1'b0;
        resp_s = 1'b1;
        burst_s = 128'hC0C0C0C0C0C0C0C0;
        tick();
        burst_s = 128'hC1C1C1C1C1C1C1C1;
        tick();
        resp_s = 1'b0;
        check("t5 mid read_o", 512'(rdo_m), 512'(1));
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) model_line[i] = '0;
        check("t5 async read_o", 512'(rdo_m), 512'(0));
        check("t5 async write_o", 512'(wro_m), 512'(0));
        check("t5 async resp_o", 512'(resp_m), 512'(0));
        check("t5 async address_o", 512'(addr_m), 512'(0));
        check("t5 async line_o", line_m, 512'(0));
        #2;
        reset = 1'b0;
        tick();
        check("t5 idle read_o", 512'(rdo_m), 512'(0));
        check("t5 no resp_o", 512'(resp_m), 512'(0));
        xfer("t5 retry", 1'b0, 1'b0, 32'h0000_001F, 32'h0000_0000, 0, 4, 64, 256, '1);
        check("t5 retry line", line_m, 512'(C_LINE));

        // 6: other width ratios, random line written then read back
        for (int k = 0; k < 3; k++) begin
            int           nb, bw, lw;
            logic [31:0]  a, ea;
            logic [511:0] wl;
            case (k)
                0:       begin sel = 3'd2; nb = 4; bw = 128; lw = 512; a = 32'h8000_007F; ea = 32'h8000_0040; end
                1:       begin sel = 3'd3; nb = 4; bw = 32;  lw = 128; a = 32'h0000_0F0F; ea = 32'h0000_0F00; end
                default: begin sel = 3'd4; nb = 8; bw = 32;  lw = 256; a = 32'hFFFF_FFFF; ea = 32'hFFFF_FFE0; end
            endcase
            for (int j = 0; j < 16; j++) wl[j*32 +: 32] = $urandom;
            wl     = wl & ({512{1'b1}} >> (512 - lw));
            line_s = wl;
            mem    = '0;
            xfer($sformatf("t6.%0d wr", k), 1'b1, 1'b0, a, ea, 0, nb, bw, lw, 32'h5555_5555);
            check($sformatf("t6.%0d memory image", k), mem, wl);
            xfer($sformatf("t6.%0d rd", k), 1'b0, 1'b0, a, ea, 0, nb, bw, lw, 32'hFFFF_F3FF);
            check($sformatf("t6.%0d round trip", k), line_m, wl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
